// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one registered bitwise logic unit among N_REQ
// requesters; results return tagged with the issuing requester's index.
module gate_op_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [3*N_REQ-1:0]       req_op,
  input  logic [WIDTH*N_REQ-1:0]   req_a,
  input  logic [WIDTH*N_REQ-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [15:0]              ops_done,
  output logic [1:0]               fsm_state
);

  localparam int IDW = $clog2(N_REQ);

  // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
  // a response transfers on the edge where rsp_valid & rsp_ready. A holder of
  // valid keeps its payload stable until the transfer edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand_idx;
  logic             gnt_found;
  logic             accept;
  int               cand;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       lat_op;
  logic [WIDTH-1:0] lat_a, lat_b;

  assign fsm_state = state;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_grant) + k) % N_REQ;
      cand_idx = IDW'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nx           = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      lat_op     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_op     <= sel_op;
        lat_a      <= sel_a;
        lat_b      <= sel_b;
        rsp_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (state == EXEC) begin
        rsp_data  <= gate_eval(lat_op, lat_a, lat_b);
        rsp_err   <= (lat_op == 3'd7);
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done  <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Self-checking bench for gate_op_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_gate_op_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [15:0]    ops_done;
  logic [1:0]     fsm_state;

  gate_op_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ops_done(ops_done), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N] === 1'b1) return (last + k) % N;
    end
    return -1;
  endfunction

  bit          m_live = 0;
  int          m_phase = 0;  // 0 waiting for a request, 1 computing, 2 presenting result
  int          m_last = N - 1;
  logic [15:0] m_ops = 16'h0;
  logic [W-1:0] exp_q[$];    // expected {data} for the op in flight
  int          m_id = 0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic [2:0] op;
    g = (m_phase == 0) ? rr_pick(m_last, req_valid) : -1;
    if (m_live) begin
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      check("ops_done", 32'(ops_done), 32'(m_ops));
      if (m_phase == 2) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
    if (rst) begin
      m_live  = 1;
      m_phase = 0;
      m_last  = N - 1;
      m_ops   = 16'h0;
      exp_q.delete();
    end else if (m_live) begin
      case (m_phase)
        0: if (g >= 0) begin
          op = req_op[g*3 +: 3];
          exp_q.delete();
          exp_q.push_back(ref_gate(op, req_a[g*W +: W], req_b[g*W +: W]));
          m_id    = g;
          m_err   = (op == 3'd7);
          m_last  = g;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready) begin
          m_ops   = m_ops + 16'd1;
          m_phase = 0;
          exp_q.delete();
        end
      endcase
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[id*3 +: 3] = op;
    req_a[id*W +: W]  = a;
    req_b[id*W +: W]  = b;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Returns one cycle after the accept edge (block is computing).
  task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bit ok;
    ok = 0;
    cyc();
    set_req(id, op, a, b);
    req_valid[id] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1;
      cyc();
    end
    req_valid[id] = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Returns one cycle after the response handshake edge.
  task automatic wait_rsp(output logic [1:0] id, output logic [W-1:0] data, output logic err);
    bit ok;
    ok = 0;
    id = '0; data = '0; err = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ok = 1;
        id = rsp_id; data = rsp_data; err = rsp_err;
      end
      cyc();
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [W-1:0] sweep_exp [8] = '{8'h5A, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

  initial begin
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         err;
    int           acc_id[8];
    int           acc_cyc[8];
    int           n_acc;
    logic [1:0]   h_id;
    logic [W-1:0] h_data;
    logic         h_err;
    logic [15:0]  h_ops;
    bit           seen;

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_ops_done", 32'(ops_done), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // single AND from requester 2
    cyc();
    set_req(2, 3'd1, 8'hF0, 8'h3C);
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id", 32'(rsp_id), 32'd2);
    check("single_rsp_data", 32'(rsp_data), 32'h30);
    check("single_rsp_err", 32'(rsp_err), 32'd0);
    cyc();
    @(negedge clk);
    check("single_ops_done", 32'(ops_done), 32'd1);

    // opcode sweep
    for (int op = 0; op < 8; op++) begin
      issue(0, 3'(op), 8'hA5, 8'h0F);
      wait_rsp(id, data, err);
      check("sweep_data", 32'(data), 32'(sweep_exp[op]));
      check("sweep_err", 32'(err), 32'(op == 7));
      check("sweep_id", 32'(id), 32'd0);
    end

    // round-robin with everyone valid
    do_reset();
    req_valid = '1;
    n_acc = 0;
    for (int c = 0; c < 60 && n_acc < 8; c++) begin
      for (int r = 0; r < N; r++) set_req(r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      @(negedge clk);
      if (req_ready != '0) begin
        check("rr_onehot", 32'($countones(req_ready)), 32'd1);
        for (int r = 0; r < N; r++) if (req_ready[r]) acc_id[n_acc] = r;
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      cyc();
    end
    req_valid = '0;
    check("rr_count", 32'(n_acc), 32'd8);
    for (int i = 0; i < n_acc; i++) begin
      check("rr_id", 32'(acc_id[i]), 32'(i % N));
      if (i > 0) check("rr_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    repeat (4) cyc();

    // backpressure
    rsp_ready = 1'b0;
    issue(1, 3'($urandom_range(1, 6)), 8'($urandom), 8'($urandom));
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else cyc();
    end
    check("bp_rsp_seen", 32'(seen), 32'd1);
    h_id = rsp_id; h_data = rsp_data; h_err = rsp_err; h_ops = ops_done;
    check("bp_id", 32'(h_id), 32'd1);
    cyc();
    req_valid = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id_stable", 32'(rsp_id), 32'(h_id));
      check("bp_data_stable", 32'(rsp_data), 32'(h_data));
      check("bp_err_stable", 32'(rsp_err), 32'(h_err));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_ops_hold", 32'(ops_done), 32'(h_ops));
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("bp_ops_inc", 32'(ops_done), 32'(h_ops + 16'd1));
    check("bp_one_handshake", 32'(rsp_valid), 32'd0);

    // reset while computing
    issue(2, 3'd5, 8'h12, 8'h34);
    rst = 1'b1;
    req_valid = 4'b1010;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_ops_done", 32'(ops_done), 32'd0);
    check("midrst_grant", 32'(req_ready), 32'h2);
    set_req(1, 3'd2, 8'h0C, 8'h30);
    cyc();
    req_valid = '0;
    wait_rsp(id, data, err);
    check("midrst_next_id", 32'(id), 32'd1);
    check("midrst_next_data", 32'(data), 32'h3C);

    // counter wrap
    repeat (2) cyc();
    force dut.ops_done = 16'hFFFE;
    m_ops = 16'hFFFE;
    cyc();
    release dut.ops_done;
    issue(3, 3'd6, 8'hF0, 8'hCC);
    wait_rsp(id, data, err);
    @(negedge clk);
    check("wrap_ffff", 32'(ops_done), 32'hFFFF);
    check("wrap_data", 32'(data), 32'hC3);
    issue(0, 3'd4, 8'h01, 8'h02);
    wait_rsp(id, data, err);
    @(negedge clk);
    check("wrap_zero", 32'(ops_done), 32'h0000);
    check("wrap_no_err", 32'(err), 32'd0);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      cyc();
      req_valid = 4'($urandom_range(0, 15));
      for (int r = 0; r < N; r++) set_req(r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    cyc();
    rst = 1'b0;
    req_valid = '0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
